// File: rtl/fp_div_pkg.sv
// Shared constants, operand classes and stage payload for the fp32 divider front end.
package fp_div_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    fp_class_t       cls_a;
    fp_class_t       cls_b;
    logic            hid_a;
    logic            hid_b;
  } s1_payload_t;

  function automatic logic is_finite(input fp_class_t c);
    return (c == ZERO) || (c == DENORM) || (c == NORMAL);
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single classifier; FP_DIV_DAZ_EN folds denormals into ZERO.
module fp32_classify
  import fp_div_pkg::*;
(
  input  logic [FP_W-1:0] i_val,
  output fp_class_t       o_cls,
  output logic            o_hidden
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp = i_val[FP_W-2:MAN_W];
  assign w_man = i_val[MAN_W-1:0];

  always_comb begin
    o_cls = NORMAL;
    if (w_exp == '0) begin
      if (w_man == '0) begin
        o_cls = ZERO;
      end else begin
`ifdef FP_DIV_DAZ_EN
        o_cls = ZERO;
`else
        o_cls = DENORM;
`endif
      end
    end else if (w_exp == EXP_MAX) begin
      o_cls = (w_man == '0) ? INF : NAN;
    end
  end

  assign o_hidden = (o_cls == NORMAL);

endmodule

// File: rtl/fp_div_operand_stage.sv
// Two-stage valid/ready operand front end for the fp32 divider: classify, then special-case decode.
// Optional FP_DIV_DAZ_EN: denormal operands treated as zero and forwarded with mantissa cleared.
module fp_div_operand_stage
  import fp_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_a,
  output logic [FP_W-1:0] out_b,
  output logic            out_red_a,
  output logic            out_red_b,
  output logic            out_special,
  output logic [FP_W-1:0] out_special_res,
  output logic            out_invalid,
  output logic            out_dz,
  input  logic            flag_clr,
  output logic            sticky_invalid,
  output logic            sticky_dz
);

  logic            w_s1_adv;
  logic            w_s2_adv;
  logic            w_out_hs;
  logic [FP_W-1:0] w_fwd_a;
  logic [FP_W-1:0] w_fwd_b;
  fp_class_t       w_cls_a;
  fp_class_t       w_cls_b;
  logic            w_hid_a;
  logic            w_hid_b;

  logic            w_sign;
  logic            w_special;
  logic [FP_W-1:0] w_res;
  logic            w_inv;
  logic            w_dz;

  logic            r_s1_valid;
  s1_payload_t     r_s1;
  logic            r_s2_valid;
  logic [FP_W-1:0] r_out_a;
  logic [FP_W-1:0] r_out_b;
  logic            r_red_a;
  logic            r_red_b;
  logic            r_special;
  logic [FP_W-1:0] r_res;
  logic            r_inv;
  logic            r_dz;
  logic            r_sticky_inv;
  logic            r_sticky_dz;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_out_hs = r_s2_valid & out_ready;

  fp32_classify u_cls_a (.i_val(in_a), .o_cls(w_cls_a), .o_hidden(w_hid_a));
  fp32_classify u_cls_b (.i_val(in_b), .o_cls(w_cls_b), .o_hidden(w_hid_b));

`ifdef FP_DIV_DAZ_EN
  assign w_fwd_a = (in_a[FP_W-2:MAN_W] == '0) ? {in_a[FP_W-1], (FP_W-1)'(0)} : in_a;
  assign w_fwd_b = (in_b[FP_W-2:MAN_W] == '0) ? {in_b[FP_W-1], (FP_W-1)'(0)} : in_b;
`else
  assign w_fwd_a = in_a;
  assign w_fwd_b = in_b;
`endif

  // Stage 1: capture operands and their classes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1.a     <= w_fwd_a;
        r_s1.b     <= w_fwd_b;
        r_s1.cls_a <= w_cls_a;
        r_s1.cls_b <= w_cls_b;
        r_s1.hid_a <= w_hid_a;
        r_s1.hid_b <= w_hid_b;
      end
    end
  end

  // Special-case decode, first matching rule wins.
  always_comb begin
    w_special = 1'b0;
    w_res     = '0;
    w_inv     = 1'b0;
    w_dz      = 1'b0;
    w_sign    = r_s1.a[FP_W-1] ^ r_s1.b[FP_W-1];
    if ((r_s1.cls_a == NAN) || (r_s1.cls_b == NAN)) begin
      w_special = 1'b1;
      w_res     = QNAN;
      w_inv     = 1'b1;
    end else if (((r_s1.cls_a == INF) && (r_s1.cls_b == INF)) ||
                 ((r_s1.cls_a == ZERO) && (r_s1.cls_b == ZERO))) begin
      w_special = 1'b1;
      w_res     = QNAN;
      w_inv     = 1'b1;
    end else if (is_finite(r_s1.cls_a) && (r_s1.cls_b == ZERO)) begin
      w_special = 1'b1;
      w_res     = {w_sign, EXP_MAX, MAN_W'(0)};
      w_dz      = 1'b1;
    end else if (r_s1.cls_a == INF) begin
      w_special = 1'b1;
      w_res     = {w_sign, EXP_MAX, MAN_W'(0)};
    end else if ((r_s1.cls_a == ZERO) || (r_s1.cls_b == INF)) begin
      w_special = 1'b1;
      w_res     = {w_sign, (FP_W-1)'(0)};
    end
  end

  // Stage 2: output registers and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_red_a      <= 1'b0;
      r_red_b      <= 1'b0;
      r_special    <= 1'b0;
      r_res        <= '0;
      r_inv        <= 1'b0;
      r_dz         <= 1'b0;
      r_sticky_inv <= 1'b0;
      r_sticky_dz  <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_a   <= r_s1.a;
          r_out_b   <= r_s1.b;
          r_red_a   <= r_s1.hid_a;
          r_red_b   <= r_s1.hid_b;
          r_special <= w_special;
          r_res     <= w_res;
          r_inv     <= w_inv;
          r_dz      <= w_dz;
        end
      end
      // A flagged handshake overrides a same-cycle clear.
      r_sticky_inv <= (r_sticky_inv & ~flag_clr) | (w_out_hs & r_inv);
      r_sticky_dz  <= (r_sticky_dz & ~flag_clr) | (w_out_hs & r_dz);
    end
  end

  assign out_valid       = r_s2_valid;
  assign out_a           = r_out_a;
  assign out_b           = r_out_b;
  assign out_red_a       = r_red_a;
  assign out_red_b       = r_red_b;
  assign out_special     = r_special;
  assign out_special_res = r_res;
  assign out_invalid     = r_inv;
  assign out_dz          = r_dz;
  assign sticky_invalid  = r_sticky_inv;
  assign sticky_dz       = r_sticky_dz;

endmodule

// File: tb/tb_fp_div_operand_stage.sv
// Self-checking bench for fp_div_operand_stage: queue-based reference model plus directed literal checks.
module tb_fp_div_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_red_a;
  logic        out_red_b;
  logic        out_special;
  logic [31:0] out_special_res;
  logic        out_invalid;
  logic        out_dz;
  logic        flag_clr = 1'b0;
  logic        sticky_invalid;
  logic        sticky_dz;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_div_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_red_a(out_red_a), .out_red_b(out_red_b),
    .out_special(out_special), .out_special_res(out_special_res),
    .out_invalid(out_invalid), .out_dz(out_dz),
    .flag_clr(flag_clr), .sticky_invalid(sticky_invalid), .sticky_dz(sticky_dz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ra;
    logic        rb;
    logic        sp;
    logic        inv;
    logic        dz;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 0 zero, 1 denormal, 2 normal, 3 infinity, 4 NaN
  function automatic int op_class(input logic [31:0] x, input bit daz);
    logic [7:0]  e = x[30:23];
    logic [22:0] m = x[22:0];
    if (e == 8'd0) return (m == 23'd0 || daz) ? 0 : 1;
    if (e == 8'd255) return (m == 23'd0) ? 3 : 4;
    return 2;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    bit daz;
    int ca, cb;
    logic s;
`ifdef FP_DIV_DAZ_EN
    daz = 1'b1;
`else
    daz = 1'b0;
`endif
    ca = op_class(a, daz);
    cb = op_class(b, daz);
    s  = a[31] ^ b[31];
    r.a  = (daz && a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
    r.b  = (daz && b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
    r.ra = (ca == 2);
    r.rb = (cb == 2);
    r.sp = 1'b1; r.inv = 1'b0; r.dz = 1'b0; r.res = 32'd0;
    if (ca == 4 || cb == 4) begin r.res = 32'h7FC00000; r.inv = 1'b1; end
    else if ((ca == 3 && cb == 3) || (ca == 0 && cb == 0)) begin r.res = 32'h7FC00000; r.inv = 1'b1; end
    else if (ca <= 2 && cb == 0) begin r.res = {s, 8'hFF, 23'd0}; r.dz = 1'b1; end
    else if (ca == 3) r.res = {s, 8'hFF, 23'd0};
    else if (ca == 0 || cb == 3) r.res = {s, 31'd0};
    else r.sp = 1'b0;
    return r;
  endfunction

  // Reference model: FIFO of accepted pairs with the edge count at which each was offered.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          qc[$];
  logic        m_inv = 1'b0;
  logic        m_dz  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete();
      m_inv = 1'b0; m_dz = 1'b0;
    end else begin
      exp_t e;
      logic hs;
      logic exp_v;
      exp_v = (qa.size() > 0) && (cyc >= qc[0] + 2);
      chk("in_ready", 32'(in_ready), 32'((qa.size() < 2) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("sticky_invalid", 32'(sticky_invalid), 32'(m_inv));
      chk("sticky_dz", 32'(sticky_dz), 32'(m_dz));
      hs = 1'b0;
      if (out_valid && qa.size() > 0) begin
        e = model(qa[0], qb[0]);
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_red_a", 32'(out_red_a), 32'(e.ra));
        chk("out_red_b", 32'(out_red_b), 32'(e.rb));
        chk("out_special", 32'(out_special), 32'(e.sp));
        chk("out_special_res", out_special_res, e.res);
        chk("out_invalid", 32'(out_invalid), 32'(e.inv));
        chk("out_dz", 32'(out_dz), 32'(e.dz));
        hs = out_ready;
      end
      m_inv = (flag_clr ? 1'b0 : m_inv) | (hs & e.inv);
      m_dz  = (flag_clr ? 1'b0 : m_dz) | (hs & e.dz);
      if (hs) begin
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
      end
      if (in_valid && in_ready) begin
        qa.push_back(in_a); qb.push_back(in_b); qc.push_back(cyc);
      end
    end
  end

  // Hold in_valid until the pair is accepted (bounded), then leave it deasserted.
  task automatic offer(input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    @(posedge clk); #2;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Offer one pair with out_ready high and check the result against literal values.
  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sp, input logic [31:0] res, input logic ra,
                          input logic inv, input logic dz, input int lat);
    int n = 0;
    out_ready = 1'b1;
    offer(a, b);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_special"}, 32'(out_special), 32'(sp));
    chk({nm, "_res"}, out_special_res, res);
    chk({nm, "_red_a"}, 32'(out_red_a), 32'(ra));
    chk({nm, "_invalid"}, 32'(out_invalid), 32'(inv));
    chk({nm, "_dz"}, 32'(out_dz), 32'(dz));
  endtask

  function automatic logic [31:0] rand_op();
    logic s = 1'($urandom);
    logic [22:0] m = 23'($urandom_range(1, 23'h7FFFFF));
    case ($urandom % 6)
      0: return {s, 31'd0};
      1: return {s, 8'd0, m};
      2: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      3: return {s, 8'hFF, 23'd0};
      4: return {s, 8'hFF, m};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_res", out_special_res, 32'd0);
    chk("rst_sticky_dz", 32'(sticky_dz), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    directed("normal", 32'h40C00000, 32'h40000000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2);
    chk("normal_out_a", out_a, 32'h40C00000);
    chk("normal_red_b", 32'(out_red_b), 32'd1);
    directed("one_div_zero", 32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 1'b1, 1'b0, 1'b1, 2);
    @(negedge clk); #1;
    chk("sticky_dz_set", 32'(sticky_dz), 32'd1);
    @(posedge clk); #2; flag_clr = 1'b1;
    @(posedge clk); #2; flag_clr = 1'b0;
    #1;
    chk("sticky_dz_cleared", 32'(sticky_dz), 32'd0);
    directed("zero_div_zero", 32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b0, 1'b1, 1'b0, 2);
    directed("negzero_div", 32'h80000000, 32'h40A00000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 2);
`ifdef FP_DIV_DAZ_EN
    directed("denorm_daz", 32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2);
`else
    directed("denorm", 32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 2);
`endif

    // Backpressure: two pairs fill the stage, the third must wait.
    @(posedge clk); #2; out_ready = 1'b0;
    offer(32'h40400000, 32'h3F800000);
    offer(32'h7F800000, 32'h40000000);
    @(posedge clk); #2;
    in_a = 32'hC0800000; in_b = 32'h00000000; in_valid = 1'b1;
    @(negedge clk); #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_a0", out_a, 32'h40400000);
    @(negedge clk); #1;
    chk("stall_out_a1", out_a, 32'h40400000);
    chk("stall_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2; out_ready = 1'b1;
    for (int i = 0; i < 20 && !(in_ready === 1'b1); i++) @(negedge clk);
    @(posedge clk); #2; in_valid = 1'b0;
    repeat (6) @(posedge clk);

    // Asynchronous reset with pairs in flight.
    directed("dz_again", 32'h3F800000, 32'h80000000, 1'b1, 32'hFF800000, 1'b1, 1'b0, 1'b1, 2);
    @(posedge clk); #2; out_ready = 1'b0;
    offer(32'h40000000, 32'h40000000);
    offer(32'h00000000, 32'h00000000);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sticky_dz", 32'(sticky_dz), 32'd0);
    chk("arst_sticky_inv", 32'(sticky_invalid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_a", out_a, 32'd0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    directed("after_rst", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1, 1'b0, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flag_clr  = ($urandom % 16) == 0;
      in_a = rand_op();
      in_b = rand_op();
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("drain_empty", 32'(qa.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_div_operand_stage.md
# fp_div_operand_stage

Two-stage, valid/ready pipelined operand front end for the single-precision divider. It accepts an IEEE-754 dividend/divisor pair and classifies each operand as zero, denormal, normal, infinity or NaN. Ordinary pairs are forwarded with their hidden-bit flags (`red_a`, `red_b`), ready for the combinational mantissa divider. Special-case pairs are resolved here with a pre-computed result, and sticky exception flags are accumulated.

## Interface
Parameters:
- none (all constants come from the shared package)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream offers an operand pair.
- `in_ready`  out  1  stage can accept this cycle.
- `in_a`  in  32  dividend, IEEE-754 single.
- `in_b`  in  32  divisor, IEEE-754 single.
- `out_valid`  out  1  forwarded pair is valid.
- `out_ready`  in  1  downstream consumes when high together with `out_valid`.
- `out_a`, `out_b`  out  32 each  operands passed unchanged.
- `out_red_a`, `out_red_b`  out  1 each  hidden bit: 1 for normal, 0 otherwise.
- `out_special`  out  1  result is fully decided here; the divider result must be ignored.
- `out_special_res`  out  32  result used when `out_special` is 1; otherwise 0.
- `out_invalid`, `out_dz`  out  1 each  per-operation invalid and divide-by-zero flags.
- `flag_clr`  in  1  synchronous clear of the sticky flags.
- `sticky_invalid`, `sticky_dz`  out  1 each  accumulated flags.

## Operation
- Per-operand classification, with e = bits[30:23] and m = bits[22:0]:
  - zero: e=0, m=0
  - denormal: e=0, m≠0
  - normal: 0<e<255
  - infinity: e=255, m=0
  - NaN: e=255, m≠0
- Special results, evaluated in priority order. sign = a[31]^b[31].
  1. Either operand NaN → 0x7FC00000, invalid.
  2. inf/inf or 0/0 → 0x7FC00000, invalid.
  3. finite nonzero / 0 → {sign, 0xFF, 0}, dz.
  4. inf / finite → {sign, 0xFF, 0}.
  5. 0 / nonzero or finite / inf → {sign, 31'b0}.
  6. Otherwise `out_special` = 0 and `out_special_res` = 0.
- Stage 1 registers the inputs and the classification results. Stage 2 registers the special decode and flags.
- Advance rules:
  - `s2_adv` = ~s2_valid | out_ready
  - `s1_adv` = ~s1_valid | s2_adv
  - `in_ready` = `s1_adv` (combinational path from `out_ready`)
- Data registers load only on their stage's advance. Otherwise they hold, so outputs stay stable while `out_valid` & ~`out_ready`.
- Sticky flags OR in `out_invalid`/`out_dz` on each output handshake (`out_valid` & `out_ready`).
- When `flag_clr` and a flagged handshake occur in the same cycle, the flagged handshake wins: the sticky flag becomes 1.

## Timing
- Latency: 2 cycles from input handshake to `out_valid` when there is no backpressure.
- Throughput: 1 pair per cycle.
- Capacity is 2 entries. With `out_ready` held low, the third offered pair sees `in_ready` = 0.
- Ordering is strictly FIFO; no pair is dropped or duplicated.
- Reset (rst_n low, asynchronous, including mid-operation): every output register clears immediately.
  - `out_valid`, both stage valids, `out_special`, `out_invalid`, `out_dz` and both sticky flags = 0.
  - `out_a`, `out_b` and `out_special_res` = 0.
  - `out_red_a`, `out_red_b` = 0.
  - `in_ready` = 1.
  - In-flight pairs are discarded.

## Configuration
- `FP_DIV_DAZ_EN` defined: denormal operands are classified as zero (denormals-are-zero). Rules 2, 3 and 5 apply to them, and `out_a`/`out_b` are forwarded with m cleared.
- Macro absent: denormals are non-special. They are forwarded unchanged with red = 0.

## Structure
- Package `fp_div_pkg` holds:
  - `fp_class_t` enum {ZERO, DENORM, NORMAL, INF, NAN}
  - `QNAN` = 32'h7FC00000
  - `EXP_MAX` = 8'hFF
- Sub-module `fp32_classify` is combinational (32-bit input → `fp_class_t`, hidden bit). It is instantiated twice, in stage 1.

## Test plan
- 0x40C00000 / 0x40000000, `out_ready` = 1 → 2 cycles later `out_valid`, `out_special` = 0, `red_a` = `red_b` = 1, operands unchanged.
- 0x3F800000 / 0x00000000 → `out_special_res` = 0x7F800000, `out_dz` = 1, `sticky_dz` = 1 after handshake. Pulsing `flag_clr` then clears it.
- 0x00000000 / 0x00000000 → 0x7FC00000 with `out_invalid` = 1. 0x80000000 / 0x40A00000 → 0x80000000 with no flags.
- 0x00000001 / 0x3F800000:
  - without the macro → non-special, `red_a` = 0;
  - with `FP_DIV_DAZ_EN` → special, result 0x00000000.
- `out_ready` = 0 while 3 pairs are offered back-to-back → 2 accepted, `in_ready` = 0 on the third. Raising `out_ready` drains all 3 in order with outputs stable while stalled.
- Assert `rst_n` low with 2 pairs in flight → `out_valid` = 0 and sticky flags = 0 without waiting for a clock edge. After release, the first new pair appears after 2 cycles.
